soc_decerr_slave: RTL and testbench

- AXI4 default slave on the SoC crossbar. It terminates every transaction whose address matches no rule in the SoC address map (Debug, ROM, CLINT, PLIC, UART, SPI, Ethernet, GPIO, DRAM).
- It sits directly downstream of the crossbar's address decode, on the default/no-match port.
- It fully completes each burst with DECERR so the master never hangs, and it records the last faulting address for debug/trap reporting.

---
 rtl/soc_decerr_slave_pkg.sv | 26 ++
 rtl/soc_decerr_slave_if.sv | 59 +++++
 rtl/soc_decerr_rd_beats.sv | 85 ++++++++
 rtl/soc_decerr_slave.sv | 160 ++++++++++++++++
 tb/tb_soc_decerr_slave.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_decerr_slave_pkg.sv
// Shared SoC definitions for the default (decode-error) slave: response codes,
// read-data filler pattern and the FSM state encodings.
package ariane_soc;

    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
    localparam logic [63:0] DecErrRespData  = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } decerr_wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } decerr_rd_state_t;

    // Saturating add of a small increment onto a 32-bit event counter.
    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/soc_decerr_slave_if.sv
// AXI4 subset seen by the decode-error slave; port names keep the slave-side
// _i/_o direction suffixes so both ends read the same as the crossbar netlist.
interface soc_decerr_slave_if #(
    parameter int IdWidth   = 5,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
) ();
    logic                 aw_valid_i;
    logic                 aw_ready_o;
    logic [IdWidth-1:0]   aw_id_i;
    logic [AddrWidth-1:0] aw_addr_i;

    logic                 w_valid_i;
    logic                 w_ready_o;
    logic                 w_last_i;

    logic                 b_valid_o;
    logic                 b_ready_i;
    logic [IdWidth-1:0]   b_id_o;
    logic [1:0]           b_resp_o;

    logic                 ar_valid_i;
    logic                 ar_ready_o;
    logic [IdWidth-1:0]   ar_id_i;
    logic [AddrWidth-1:0] ar_addr_i;
    logic [7:0]           ar_len_i;

    logic                 r_valid_o;
    logic                 r_ready_i;
    logic [IdWidth-1:0]   r_id_o;
    logic [DataWidth-1:0] r_data_o;
    logic [1:0]           r_resp_o;
    logic                 r_last_o;

    modport slave (
        input  aw_valid_i, aw_id_i, aw_addr_i,
        input  w_valid_i, w_last_i,
        input  b_ready_i,
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i,
        input  r_ready_i,
        output aw_ready_o, w_ready_o,
        output b_valid_o, b_id_o, b_resp_o,
        output ar_ready_o,
        output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

    modport master (
        output aw_valid_i, aw_id_i, aw_addr_i,
        output w_valid_i, w_last_i,
        output b_ready_i,
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i,
        output r_ready_i,
        input  aw_ready_o, w_ready_o,
        input  b_valid_o, b_id_o, b_resp_o,
        input  ar_ready_o,
        input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
    );

endinterface

// File: rtl/soc_decerr_rd_beats.sv
// Read-side burst generator for error/stub slaves: accepts one AR, then emits
// ar_len+1 R beats with registered handshake outputs and last-beat flag.
module soc_decerr_rd_beats
    import ariane_soc::*;
#(
    parameter int IdWidth = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ar_valid_i,
    input  logic [IdWidth-1:0] ar_id_i,
    input  logic [7:0]         ar_len_i,
    input  logic               r_ready_i,
    output logic               ar_ready_o,
    output logic               ar_hs_o,
    output logic               r_valid_o,
    output logic               r_last_o,
    output logic [IdWidth-1:0] r_id_o
);

    decerr_rd_state_t   state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic               ar_ready_q, ar_ready_d;
    logic               r_valid_q, r_valid_d;
    logic               r_last_q, r_last_d;
    logic               ar_hs, r_hs;

    assign ar_hs = ar_valid_i && ar_ready_q;
    assign r_hs  = r_valid_q && r_ready_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    id_d    = ar_id_i;
                    cnt_d   = ar_len_i;
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                // Counter holds remaining beats after the current one; zero means last.
                if (r_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
        ar_ready_d = (state_d == R_IDLE);
        r_valid_d  = (state_d == R_DATA);
        r_last_d   = (state_d == R_DATA) && (cnt_d == 8'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= R_IDLE;
            cnt_q      <= 8'd0;
            id_q       <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
        end
    end

    assign ar_ready_o = ar_ready_q;
    assign ar_hs_o    = ar_hs;
    assign r_valid_o  = r_valid_q;
    assign r_last_o   = r_last_q;
    assign r_id_o     = id_q;

endmodule

// File: rtl/soc_decerr_slave.sv
// AXI4 default slave: completes every unmapped burst with DECERR and records the
// last faulting address. Define SOC_DECERR_CNT_EN to add the err_count_o counter.
module soc_decerr_slave
    import ariane_soc::*;
#(
    parameter int          IdWidth   = 5,
    parameter int          AddrWidth = 64,
    parameter int          DataWidth = 64,
    parameter logic [63:0] RespData  = DecErrRespData
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    soc_decerr_slave_if.slave    bus,
    output logic                 err_pulse_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_is_write_o
`ifdef SOC_DECERR_CNT_EN
    ,
    output logic [31:0]          err_count_o
`endif
);

    // ------------------------------------------------------------ write side
    decerr_wr_state_t   w_state_q, w_state_d;
    logic [IdWidth-1:0] b_id_q, b_id_d;
    logic               aw_ready_q, aw_ready_d;
    logic               w_ready_q, w_ready_d;
    logic               b_valid_q, b_valid_d;
    logic               aw_hs, w_hs, b_hs;

    assign aw_hs = bus.aw_valid_i && aw_ready_q;
    assign w_hs  = bus.w_valid_i && w_ready_q;
    assign b_hs  = b_valid_q && bus.b_ready_i;

    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    b_id_d    = bus.aw_id_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // Beats are discarded; only w_last ends the burst.
                if (w_hs && bus.w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        b_valid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q  <= W_IDLE;
            b_id_q     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            b_id_q     <= b_id_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    assign bus.aw_ready_o = aw_ready_q;
    assign bus.w_ready_o  = w_ready_q;
    assign bus.b_valid_o  = b_valid_q;
    assign bus.b_id_o     = b_id_q;
    assign bus.b_resp_o   = AXI_RESP_DECERR;

    // ------------------------------------------------------------- read side
    logic ar_hs;

    soc_decerr_rd_beats #(
        .IdWidth (IdWidth)
    ) u_rd_beats (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ar_valid_i (bus.ar_valid_i),
        .ar_id_i    (bus.ar_id_i),
        .ar_len_i   (bus.ar_len_i),
        .r_ready_i  (bus.r_ready_i),
        .ar_ready_o (bus.ar_ready_o),
        .ar_hs_o    (ar_hs),
        .r_valid_o  (bus.r_valid_o),
        .r_last_o   (bus.r_last_o),
        .r_id_o     (bus.r_id_o)
    );

    assign bus.r_data_o = DataWidth'(RespData);
    assign bus.r_resp_o = AXI_RESP_DECERR;

    // ---------------------------------------------------------------- status
    logic                 err_pulse_q, err_pulse_d;
    logic [AddrWidth-1:0] err_addr_q, err_addr_d;
    logic                 err_is_write_q, err_is_write_d;

    always_comb begin
        err_pulse_d    = aw_hs || ar_hs;
        err_addr_d     = err_addr_q;
        err_is_write_d = err_is_write_q;
        // A simultaneous AW and AR reports the write address.
        if (aw_hs) begin
            err_addr_d     = bus.aw_addr_i;
            err_is_write_d = 1'b1;
        end else if (ar_hs) begin
            err_addr_d     = bus.ar_addr_i;
            err_is_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pulse_q    <= 1'b0;
            err_addr_q     <= '0;
            err_is_write_q <= 1'b0;
        end else begin
            err_pulse_q    <= err_pulse_d;
            err_addr_q     <= err_addr_d;
            err_is_write_q <= err_is_write_d;
        end
    end

    assign err_pulse_o    = err_pulse_q;
    assign err_addr_o     = err_addr_q;
    assign err_is_write_o = err_is_write_q;

`ifdef SOC_DECERR_CNT_EN
    logic [31:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = sat_add32(err_count_q, {1'b0, aw_hs} + {1'b0, ar_hs});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_q <= 32'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;
`endif

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Directed self-checking bench for soc_decerr_slave (both SOC_DECERR_CNT_EN builds).
module tb_soc_decerr_slave;

    localparam int IdW = 5;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam logic [63:0] FILL = 64'hDEAD_BEEF_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_pulse;
    logic [AW-1:0] err_addr;
    logic          err_is_write;
`ifdef SOC_DECERR_CNT_EN
    logic [31:0]   err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    soc_decerr_slave_if #(.IdWidth(IdW), .AddrWidth(AW), .DataWidth(DW)) bus ();

    soc_decerr_slave #(
        .IdWidth   (IdW),
        .AddrWidth (AW),
        .DataWidth (DW),
        .RespData  (FILL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .err_pulse_o    (err_pulse),
        .err_addr_o     (err_addr),
        .err_is_write_o (err_is_write)
`ifdef SOC_DECERR_CNT_EN
        ,
        .err_count_o    (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats;
        int fails_at_start;

        rst = 1'b1;
        bus.aw_valid_i = 1'b0; bus.aw_id_i = '0; bus.aw_addr_i = '0;
        bus.w_valid_i  = 1'b0; bus.w_last_i = 1'b0;
        bus.b_ready_i  = 1'b0;
        bus.ar_valid_i = 1'b0; bus.ar_id_i = '0; bus.ar_addr_i = '0; bus.ar_len_i = '0;
        bus.r_ready_i  = 1'b0;

        // ---------------- reset state
        step(); step();
        chk("rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
        chk("rst_ar_ready", 64'(bus.ar_ready_o), 64'd0);
        chk("rst_w_ready",  64'(bus.w_ready_o),  64'd0);
        chk("rst_b_valid",  64'(bus.b_valid_o),  64'd0);
        chk("rst_r_valid",  64'(bus.r_valid_o),  64'd0);
        chk("rst_b_id",     64'(bus.b_id_o),     64'd0);
        chk("rst_r_id",     64'(bus.r_id_o),     64'd0);
        chk("rst_pulse",    64'(err_pulse),      64'd0);
        chk("rst_addr",     err_addr,            64'd0);
        chk("rst_is_write", 64'(err_is_write),   64'd0);
`ifdef SOC_DECERR_CNT_EN
        chk("rst_count",    64'(err_count),      64'd0);
`endif
        rst = 1'b0;
        step();
        chk("idle_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        chk("idle_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        $display("[TB] txn reset done");

        // ---------------- single write, one beat
        bus.aw_valid_i = 1'b1; bus.aw_id_i = 5'h13; bus.aw_addr_i = 64'h5000_0000;
        step();
        bus.aw_valid_i = 1'b0;
        chk("wr1_aw_ready_low", 64'(bus.aw_ready_o), 64'd0);
        chk("wr1_w_ready",      64'(bus.w_ready_o),  64'd1);
        chk("wr1_pulse",        64'(err_pulse),      64'd1);
        chk("wr1_addr",         err_addr,            64'h5000_0000);
        chk("wr1_is_write",     64'(err_is_write),   64'd1);
        bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1;
        step();
        bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        chk("wr1_pulse_once", 64'(err_pulse),     64'd0);
        chk("wr1_b_valid",    64'(bus.b_valid_o), 64'd1);
        chk("wr1_b_id",       64'(bus.b_id_o),    64'h13);
        chk("wr1_b_resp",     64'(bus.b_resp_o),  64'd3);
        chk("wr1_w_ready_off",64'(bus.w_ready_o), 64'd0);
        step();
        chk("wr1_b_hold",     64'(bus.b_valid_o), 64'd1);
        chk("wr1_b_id_hold",  64'(bus.b_id_o),    64'h13);
        chk("wr1_aw_ready_resp", 64'(bus.aw_ready_o), 64'd0);
        bus.b_ready_i = 1'b1;
        step();
        bus.b_ready_i = 1'b0;
        chk("wr1_b_done",   64'(bus.b_valid_o),  64'd0);
        chk("wr1_aw_ready", 64'(bus.aw_ready_o), 64'd1);
        $display("[TB] txn write id=13 addr=50000000 single beat");

        // ---------------- read len 3
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 5'h02; bus.ar_addr_i = 64'h9000_0040; bus.ar_len_i = 8'd3;
        bus.r_ready_i = 1'b1;
        step();
        bus.ar_valid_i = 1'b0;
        chk("rd4_pulse",    64'(err_pulse),    64'd1);
        chk("rd4_addr",     err_addr,          64'h9000_0040);
        chk("rd4_is_write", 64'(err_is_write), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("rd4_r_valid",  64'(bus.r_valid_o),  64'd1);
            chk("rd4_r_data",   bus.r_data_o,        FILL);
            chk("rd4_r_resp",   64'(bus.r_resp_o),   64'd3);
            chk("rd4_r_id",     64'(bus.r_id_o),     64'h02);
            chk("rd4_r_last",   64'(bus.r_last_o),   (k == 4) ? 64'd1 : 64'd0);
            chk("rd4_ar_ready", 64'(bus.ar_ready_o), 64'd0);
            step();
        end
        chk("rd4_done",     64'(bus.r_valid_o),  64'd0);
        chk("rd4_ar_ready_back", 64'(bus.ar_ready_o), 64'd1);
        bus.r_ready_i = 1'b0;
        $display("[TB] txn read id=02 len=3 four beats");

        // ---------------- read len 255 with stalls
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 5'h01; bus.ar_addr_i = 64'h8800_0000; bus.ar_len_i = 8'd255;
        step();
        bus.ar_valid_i = 1'b0;
        beats = 0;
        fails_at_start = n_fail;
        for (int cyc = 0; cyc < 1200 && beats < 256 && n_fail - fails_at_start < 10; cyc++) begin
            bus.r_ready_i = cyc[0];
            chk("rd256_r_valid", 64'(bus.r_valid_o), 64'd1);
            chk("rd256_r_last",  64'(bus.r_last_o),  (beats == 255) ? 64'd1 : 64'd0);
            if (bus.r_ready_i) beats++;
            step();
        end
        bus.r_ready_i = 1'b0;
        chk("rd256_beats",  64'(beats),          64'd256);
        chk("rd256_done",   64'(bus.r_valid_o),  64'd0);
        $display("[TB] txn read id=01 len=255 beats=%0d", beats);

        // ---------------- simultaneous AW and AR (fresh reset so counter starts at 0)
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.aw_valid_i = 1'b1; bus.aw_id_i = 5'h04; bus.aw_addr_i = 64'h6000_0000;
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 5'h09; bus.ar_addr_i = 64'h7000_0000; bus.ar_len_i = 8'd0;
        step();
        bus.aw_valid_i = 1'b0; bus.ar_valid_i = 1'b0;
        chk("both_pulse",    64'(err_pulse),    64'd1);
        chk("both_addr",     err_addr,          64'h6000_0000);
        chk("both_is_write", 64'(err_is_write), 64'd1);
`ifdef SOC_DECERR_CNT_EN
        chk("both_count",    64'(err_count),    64'd2);
`endif
        chk("both_r_valid",  64'(bus.r_valid_o), 64'd1);
        chk("both_r_last",   64'(bus.r_last_o),  64'd1);
        chk("both_r_id",     64'(bus.r_id_o),    64'h09);
        chk("both_w_ready",  64'(bus.w_ready_o), 64'd1);
        bus.r_ready_i = 1'b1; bus.w_valid_i = 1'b1; bus.w_last_i = 1'b1; bus.b_ready_i = 1'b1;
        step();
        bus.r_ready_i = 1'b0; bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        chk("both_single_pulse", 64'(err_pulse),     64'd0);
        chk("both_r_done",       64'(bus.r_valid_o), 64'd0);
        chk("both_b_valid",      64'(bus.b_valid_o), 64'd1);
        chk("both_b_id",         64'(bus.b_id_o),    64'h04);
        step();
        bus.b_ready_i = 1'b0;
        chk("both_b_done",       64'(bus.b_valid_o), 64'd0);
        chk("both_addr_kept",    err_addr,           64'h6000_0000);
        $display("[TB] txn concurrent aw=60000000 ar=70000000");

        // ---------------- W before AW, then three-beat burst
        bus.w_valid_i = 1'b1; bus.w_last_i = 1'b0;
        step();
        chk("wfirst_w_ready_a", 64'(bus.w_ready_o), 64'd0);
        step();
        chk("wfirst_w_ready_b", 64'(bus.w_ready_o), 64'd0);
        bus.aw_valid_i = 1'b1; bus.aw_id_i = 5'h07; bus.aw_addr_i = 64'h0000_1000;
        step();
        bus.aw_valid_i = 1'b0;
        chk("wfirst_w_ready_on", 64'(bus.w_ready_o), 64'd1);
        step();
        chk("wfirst_b_after1", 64'(bus.b_valid_o), 64'd0);
        bus.w_last_i = 1'b0;
        step();
        chk("wfirst_b_after2", 64'(bus.b_valid_o), 64'd0);
        bus.w_last_i = 1'b1;
        step();
        bus.w_valid_i = 1'b0; bus.w_last_i = 1'b0;
        chk("wfirst_b_valid", 64'(bus.b_valid_o), 64'd1);
        chk("wfirst_b_id",    64'(bus.b_id_o),    64'h07);
        bus.b_ready_i = 1'b1;
        step();
        bus.b_ready_i = 1'b0;
        chk("wfirst_b_done",  64'(bus.b_valid_o), 64'd0);
        step();
        chk("wfirst_single_b", 64'(bus.b_valid_o), 64'd0);
        $display("[TB] txn write id=07 three beats after early W");

        // ---------------- reset during read burst
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 5'h03; bus.ar_addr_i = 64'hA000_0000; bus.ar_len_i = 8'd7;
        bus.r_ready_i = 1'b1;
        step();
        bus.ar_valid_i = 1'b0;
        step();
        chk("rstmid_beat2_valid", 64'(bus.r_valid_o), 64'd1);
        chk("rstmid_beat2_last",  64'(bus.r_last_o),  64'd0);
        rst = 1'b1; bus.r_ready_i = 1'b0;
        step();
        rst = 1'b0;
        chk("rstmid_r_valid",  64'(bus.r_valid_o), 64'd0);
        chk("rstmid_err_addr", err_addr,           64'd0);
        step();
        chk("rstmid_ar_ready", 64'(bus.ar_ready_o), 64'd1);
        chk("rstmid_r_idle",   64'(bus.r_valid_o),  64'd0);
        bus.ar_valid_i = 1'b1; bus.ar_id_i = 5'h06; bus.ar_addr_i = 64'hB000_0000; bus.ar_len_i = 8'd0;
        step();
        bus.ar_valid_i = 1'b0;
        chk("rstmid_new_valid", 64'(bus.r_valid_o), 64'd1);
        chk("rstmid_new_last",  64'(bus.r_last_o),  64'd1);
        chk("rstmid_new_id",    64'(bus.r_id_o),    64'h06);
        bus.r_ready_i = 1'b1;
        step();
        bus.r_ready_i = 1'b0;
        chk("rstmid_new_done",  64'(bus.r_valid_o), 64'd0);
        $display("[TB] txn reset mid-burst then read id=06 len=0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
